demod_segment_scheduler: RTL and testbench
==========================================

// Module: demod_segment_scheduler
// PURPOSE
//  Sequences one demodulation frame of NUM_SEG Q16.16 samples through the shared single-segment slicer datapath.
//  - Issues one sample per cycle, tagged with its segment index and its ref/ref_m pair.
//  - Tracks in-flight work with a credit counter.
//  - Writes each slicer result into the segment register bank.
//  - Provides the start/busy/valid frame handshake.
//  - Sits between the input sample stream and the segment slicer plus the segment register bank.
// PARAMETERS
//  DATA_W   32  sample/result width, Q16.16 two's complement
//  NUM_SEG  10  segments per frame (>=2)
//  IDX_W     4  segment index width, 2**IDX_W >= NUM_SEG
//  MAX_OUT   3  max outstanding slicer requests (>= slicer latency + 1 for full throughput)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset
//  start        in   1       frame start pulse; honoured only in IDLE
//  abort        in   1       cancel current frame
//  in_valid     in   1       input sample valid
//  in_data      in   DATA_W  input sample
//  in_ready     out  1       sample accepted when in_valid & in_ready
//  dp_req       out  1       slicer request strobe
//  dp_idx       out  IDX_W   segment index of the request
//  dp_data      out  DATA_W  sample to slice
//  dp_ref       out  DATA_W  value for non-negative sample
//  dp_ref_m     out  DATA_W  value for negative sample
//  dp_res_valid in   1       slicer result strobe (in order)
//  dp_res_idx   in   IDX_W   index of returned result
//  dp_res_data  in   DATA_W  slicer result
//  seg_we       out  1       segment bank write enable
//  seg_idx      out  IDX_W   segment bank write address
//  seg_data     out  DATA_W  segment bank write data
//  busy         out  1       frame in progress (ISSUE/DRAIN/FLUSH)
//  valid        out  1       one-cycle frame-complete pulse
//  err          out  1       sticky: result index mismatch or spurious result
// BEHAVIOUR
//  Reset values:
//  - All outputs are 0. State is IDLE. issue_cnt, ret_cnt and outstanding are 0. err is 0.
//  Reference pattern:
//  - Even idx: dp_ref = 32'h0001_0000 (+1.0), dp_ref_m = 32'hFFFF_0000 (-1.0).
//  - Odd idx: the two values are swapped.
//  FSM:
//  - IDLE -> ISSUE on start (abort low). busy is 1 from the next cycle.
//  - ISSUE: in_ready = (outstanding < MAX_OUT).
//    - Each accepted sample registers dp_req = 1 the next cycle, with dp_idx = issue_cnt and dp_data = in_data.
//    - issue_cnt then increments.
//    - After the NUM_SEG-th accept: -> DRAIN, and in_ready drops the following cycle.
//  - DRAIN: in_ready = 0. When ret_cnt == NUM_SEG -> DONE.
//  - DONE: valid = 1 for exactly one cycle, busy = 0, counters clear -> IDLE.
//  - abort in ISSUE or DRAIN -> FLUSH.
//    - FLUSH: in_ready = 0, seg_we suppressed, returning results are counted but dropped.
//    - FLUSH -> IDLE when outstanding == 0. valid is never pulsed for an aborted frame.
//  - abort in IDLE or DONE: ignored.
//  - start outside IDLE: ignored.
//  Result path, 1-cycle latency:
//  - A dp_res_valid in ISSUE/DRAIN produces seg_we = 1 next cycle.
//  - seg_idx and seg_data are registered copies of dp_res_idx and dp_res_data.
//  - ret_cnt increments on each such result.
//  Credits:
//  - outstanding += accept (the cycle in_valid & in_ready), -= dp_res_valid.
//  - Simultaneous accept and return: outstanding is unchanged.
//  - outstanding never exceeds MAX_OUT.
//  err (sticky until reset):
//  - Set when dp_res_idx != ret_cnt in ISSUE/DRAIN.
//  - Set on a dp_res_valid in IDLE/DONE, or whenever outstanding == 0. That result is dropped.
//  - A mismatched result is still written.
//  Widths:
//  - issue_cnt and ret_cnt are IDX_W wide.
//  - outstanding is $clog2(MAX_OUT+1) wide.
//  - Counters never wrap within a frame.
//  Reset mid-frame: immediate return to the reset values. In-flight results arriving later are flagged via err.
// STRUCTURE
//  Shared package demod_pkg:
//  - Q16_ONE = 32'h0001_0000 and Q16_MONE = 32'hFFFF_0000.
//  - State enum: IDLE, ISSUE, DRAIN, DONE, FLUSH.
//  Sub-module demod_seg_ref_sel: combinational idx-parity -> {dp_ref, dp_ref_m}. Everything else is flat.
// TESTING
//  1. Ten back-to-back samples, 2-cycle slicer model:
//     - valid pulses once; seg_idx goes 0..9 in order.
//     - seg_data is 0x0001_0000 for a non-negative even-index sample.
//     - busy falls together with valid.
//  2. Slicer model with latency 5, MAX_OUT=3:
//     - in_ready stalls with 3 outstanding.
//     - No fourth dp_req until a result returns.
//     - The frame completes with err=0.
//  3. abort after 4 accepts, with 2 in flight:
//     - Enters FLUSH; the 2 returns produce no seg_we.
//     - Back to IDLE with busy=0; valid never asserted.
//  4. Slicer model returns idx 3 when 2 is expected: err=1 and stays 1 through the next frame.
//  5. start during ISSUE, and dp_res_valid in IDLE:
//     - The start is ignored; the frame is unaffected.
//     - err=1 and no seg_we.
//  6. reset asserted mid-DRAIN: all outputs 0 asynchronously; a new start after release runs a clean frame.

Source files
------------

// File: rtl/demod_pkg.sv
// Shared definitions for the demodulation segment scheduler.
// Q16.16 reference constants (+1.0 / -1.0) and the frame FSM state encoding.
// No ports; imported by the scheduler and its reference selector.
package demod_pkg;

  localparam logic [31:0] Q16_ONE  = 32'h0001_0000;
  localparam logic [31:0] Q16_MONE = 32'hFFFF_0000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE,
    FLUSH
  } state_t;

endpackage

// File: rtl/demod_seg_ref_sel.sv
// Segment reference selector: maps segment-index parity to the slicer ref pair.
// Ports: odd (index LSB) in; ref_p (value for non-negative sample), ref_m (value for negative sample) out.
// Purely combinational, zero latency, no flow control.
module demod_seg_ref_sel
  import demod_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              odd,
  output logic [DATA_W-1:0] ref_p,
  output logic [DATA_W-1:0] ref_m
);

  // Even segments slice to +1/-1, odd segments use the inverted polarity.
  assign ref_p = odd ? DATA_W'(Q16_MONE) : DATA_W'(Q16_ONE);
  assign ref_m = odd ? DATA_W'(Q16_ONE)  : DATA_W'(Q16_MONE);

endmodule

// File: rtl/demod_segment_scheduler.sv
// Frame scheduler: pushes NUM_SEG Q16.16 samples through the shared slicer and
// writes each in-order result into the segment bank; start/busy/valid handshake.
// Ports: clk/reset (async, active-low); start/abort control; in_valid/in_data/in_ready
// sample stream; dp_* slicer request (1 cycle after accept) and result return;
// seg_we/seg_idx/seg_data bank write (1 cycle after result); busy, valid, sticky err.
// Backpressure: in_ready is withheld once MAX_OUT slicer requests are outstanding.
module demod_segment_scheduler
  import demod_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SEG = 10,
  parameter int IDX_W   = 4,
  parameter int MAX_OUT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dp_req,
  output logic [IDX_W-1:0]  dp_idx,
  output logic [DATA_W-1:0] dp_data,
  output logic [DATA_W-1:0] dp_ref,
  output logic [DATA_W-1:0] dp_ref_m,
  input  logic              dp_res_valid,
  input  logic [IDX_W-1:0]  dp_res_idx,
  input  logic [DATA_W-1:0] dp_res_data,
  output logic              seg_we,
  output logic [IDX_W-1:0]  seg_idx,
  output logic [DATA_W-1:0] seg_data,
  output logic              busy,
  output logic              valid,
  output logic              err
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);

  state_t            state;
  logic [IDX_W-1:0]  issue_cnt;
  logic [IDX_W-1:0]  ret_cnt;
  logic [OUT_W-1:0]  outstanding;
  logic [DATA_W-1:0] nxt_ref;
  logic [DATA_W-1:0] nxt_ref_m;

  logic accept;
  logic active;
  logic ret_ok;
  logic wr;
  logic spurious;
  logic idx_bad;

  assign in_ready = (state == ISSUE) && (outstanding < OUT_W'(MAX_OUT));
  assign accept   = in_valid && in_ready;
  assign active   = (state == ISSUE) || (state == DRAIN);
  // A result is only legitimate when it retires a credit of the current frame.
  assign ret_ok   = dp_res_valid && (outstanding != '0) && (active || (state == FLUSH));
  assign spurious = dp_res_valid && !ret_ok;
  // Results retiring during FLUSH consume credit but never reach the bank.
  assign wr       = ret_ok && active;
  assign idx_bad  = wr && (dp_res_idx != ret_cnt);

  demod_seg_ref_sel #(
    .DATA_W (DATA_W)
  ) u_ref_sel (
    .odd   (issue_cnt[0]),
    .ref_p (nxt_ref),
    .ref_m (nxt_ref_m)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      err         <= 1'b0;
      dp_req      <= 1'b0;
      dp_idx      <= '0;
      dp_data     <= '0;
      dp_ref      <= '0;
      dp_ref_m    <= '0;
      seg_we      <= 1'b0;
      seg_idx     <= '0;
      seg_data    <= '0;
    end else begin
      // Credit counter: a simultaneous accept and return cancel out.
      if (accept && !ret_ok) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (!accept && ret_ok) begin
        outstanding <= outstanding - OUT_W'(1);
      end

      dp_req <= accept;
      if (accept) begin
        dp_idx    <= issue_cnt;
        dp_data   <= in_data;
        dp_ref    <= nxt_ref;
        dp_ref_m  <= nxt_ref_m;
        issue_cnt <= issue_cnt + IDX_W'(1);
      end

      seg_we <= wr;
      if (wr) begin
        seg_idx  <= dp_res_idx;
        seg_data <= dp_res_data;
        ret_cnt  <= ret_cnt + IDX_W'(1);
      end

      if (idx_bad || spurious) begin
        err <= 1'b1;
      end

      // Counter clears below never collide with the increments above: accepts
      // only happen in ISSUE and bank writes only in ISSUE/DRAIN.
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (abort) begin
            state <= FLUSH;
          end else if (accept && (issue_cnt == IDX_W'(NUM_SEG - 1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= FLUSH;
          end else if (ret_cnt == IDX_W'(NUM_SEG)) begin
            state <= DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          valid     <= 1'b0;
          issue_cnt <= '0;
          ret_cnt   <= '0;
        end
        FLUSH: begin
          if (outstanding == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demod_segment_scheduler.sv
// Directed bench for demod_segment_scheduler with a fixed-latency in-order slicer model.
// Ports: none (top-level bench); drives the DUT at negedge, samples at negedge.
// The slicer model reacts 1 time unit after each rising edge.
module tb_demod_segment_scheduler;
  import demod_pkg::*;

  localparam int DATA_W  = 32;
  localparam int NUM_SEG = 10;
  localparam int IDX_W   = 4;
  localparam int MAX_OUT = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              dp_req;
  logic [IDX_W-1:0]  dp_idx;
  logic [DATA_W-1:0] dp_data;
  logic [DATA_W-1:0] dp_ref;
  logic [DATA_W-1:0] dp_ref_m;
  logic              dp_res_valid = 1'b0;
  logic [IDX_W-1:0]  dp_res_idx = '0;
  logic [DATA_W-1:0] dp_res_data = '0;
  logic              seg_we;
  logic [IDX_W-1:0]  seg_idx;
  logic [DATA_W-1:0] seg_data;
  logic              busy;
  logic              valid;
  logic              err;

  demod_segment_scheduler #(
    .DATA_W  (DATA_W),
    .NUM_SEG (NUM_SEG),
    .IDX_W   (IDX_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .dp_req       (dp_req),
    .dp_idx       (dp_idx),
    .dp_data      (dp_data),
    .dp_ref       (dp_ref),
    .dp_ref_m     (dp_ref_m),
    .dp_res_valid (dp_res_valid),
    .dp_res_idx   (dp_res_idx),
    .dp_res_data  (dp_res_data),
    .seg_we       (seg_we),
    .seg_idx      (seg_idx),
    .seg_data     (seg_data),
    .busy         (busy),
    .valid        (valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [DATA_W-1:0] samp [NUM_SEG];

  // Independent expectation: even index slices sign to +/-1, odd index inverts.
  function automatic logic [DATA_W-1:0] exp_slice(input int i);
    logic even;
    even = (i % 2) == 0;
    return (even ^ samp[i][DATA_W-1]) ? Q16_ONE : Q16_MONE;
  endfunction

  // ---------------- slicer model ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int lat = 2;
  bit corrupt = 1'b0;
  bit spur_req = 1'b0;
  int inflight = 0;
  int max_inflight = 0;
  int res_cnt = 0;
  logic [IDX_W-1:0]  q_idx [$];
  logic [DATA_W-1:0] q_dat [$];
  int                q_due [$];

  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      q_idx.delete();
      q_dat.delete();
      q_due.delete();
      inflight     = 0;
      dp_res_valid = 1'b0;
      dp_res_idx   = '0;
      dp_res_data  = '0;
    end else begin
      if (dp_req) begin
        q_idx.push_back((corrupt && (dp_idx == IDX_W'(2))) ? IDX_W'(3) : dp_idx);
        q_dat.push_back(dp_data[DATA_W-1] ? dp_ref_m : dp_ref);
        q_due.push_back(cyc + lat - 1);
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
      end
      dp_res_valid = 1'b0;
      if (spur_req) begin
        dp_res_valid = 1'b1;
        dp_res_idx   = '0;
        dp_res_data  = 32'h1234_5678;
      end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
        dp_res_valid = 1'b1;
        dp_res_idx   = q_idx.pop_front();
        dp_res_data  = q_dat.pop_front();
        void'(q_due.pop_front());
        inflight--;
        res_cnt++;
      end
    end
  end

  // ---------------- output monitor ----------------
  int   we_cnt = 0;
  int   valid_cnt = 0;
  int   req_cnt = 0;
  int   bv_bad = 0;
  logic prev_busy = 1'b0;
  logic [IDX_W-1:0]  log_idx [$];
  logic [DATA_W-1:0] log_dat [$];

  always @(negedge clk) begin
    if (seg_we) begin
      we_cnt++;
      log_idx.push_back(seg_idx);
      log_dat.push_back(seg_data);
    end
    if (valid) begin
      valid_cnt++;
      if (busy || !prev_busy) bv_bad++;
    end
    if (dp_req) req_cnt++;
    prev_busy = busy;
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(tag, busy, 1);
  endtask

  task automatic drive_frame(input int n, input int abort_at, input int start_at, output int stalls);
    int   i = 0;
    int   guard = 0;
    logic acc;
    stalls = 0;
    while (i < n && guard < 400) begin
      in_valid = 1'b1;
      in_data  = samp[i];
      acc      = in_ready;
      abort    = (i == abort_at) && acc;
      start    = (i == start_at);
      if (!acc) stalls++;
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
    check("accept_budget", i, n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {in_ready, dp_req, seg_we, busy, valid, err, dp_idx, seg_idx}, 0);
    check({tag, "_dp"}, {dp_data, dp_ref}, 0);
    check({tag, "_seg"}, {dp_ref_m, seg_data}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int st;
  int b_we, b_v, b_req, b_res, b_log;

  initial begin
    samp[0] = 32'h0000_5000;
    samp[1] = 32'hFFFF_8000;
    samp[2] = 32'h0002_0000;
    samp[3] = 32'h0000_0000;
    samp[4] = 32'h8000_0000;
    samp[5] = 32'h7FFF_FFFF;
    samp[6] = 32'hFFFF_FFFF;
    samp[7] = 32'h0000_0001;
    samp[8] = 32'h0001_0000;
    samp[9] = 32'hC000_0000;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // 1: back-to-back frame, 2-cycle slicer
    lat = 2;
    b_we = we_cnt; b_v = valid_cnt; b_req = req_cnt; b_log = log_idx.size();
    pulse_start("t1_busy_start");
    drive_frame(NUM_SEG, -1, -1, st);
    check("t1_no_stall", st, 0);
    wait_idle(60, "t1_idle");
    check("t1_valid_cnt", valid_cnt - b_v, 1);
    check("t1_we_cnt", we_cnt - b_we, NUM_SEG);
    check("t1_req_cnt", req_cnt - b_req, NUM_SEG);
    for (int i = 0; i < NUM_SEG; i++) begin
      check($sformatf("t1_seg_idx%0d", i), log_idx[b_log + i], i);
      check($sformatf("t1_seg_data%0d", i), log_dat[b_log + i], exp_slice(i));
    end
    check("t1_busy_with_valid", bv_bad, 0);
    check("t1_err", err, 0);
    check("t1_valid_low", valid, 0);

    // 2: latency 5 saturates the three credits
    lat = 5;
    b_we = we_cnt; b_v = valid_cnt;
    pulse_start("t2_busy_start");
    drive_frame(NUM_SEG, -1, -1, st);
    check("t2_stalled", st > 0, 1);
    wait_idle(150, "t2_idle");
    check("t2_max_inflight", max_inflight, MAX_OUT);
    check("t2_valid_cnt", valid_cnt - b_v, 1);
    check("t2_we_cnt", we_cnt - b_we, NUM_SEG);
    check("t2_err", err, 0);

    // 3: abort on the 4th accept with two requests still in flight
    lat = 3;
    b_we = we_cnt; b_v = valid_cnt; b_req = req_cnt; b_res = res_cnt;
    pulse_start("t3_busy_start");
    drive_frame(4, 3, -1, st);
    check("t3_flush_busy", busy, 1);
    check("t3_flush_ready", in_ready, 0);
    wait_idle(50, "t3_idle");
    check("t3_we_cnt", we_cnt - b_we, 2);
    check("t3_valid_cnt", valid_cnt - b_v, 0);
    check("t3_req_cnt", req_cnt - b_req, 4);
    check("t3_res_cnt", res_cnt - b_res, 4);
    check("t3_err", err, 0);

    // 4: slicer returns index 3 where 2 is due
    lat = 2;
    corrupt = 1'b1;
    b_we = we_cnt; b_v = valid_cnt; b_log = log_idx.size();
    pulse_start("t4_busy_start");
    drive_frame(NUM_SEG, -1, -1, st);
    wait_idle(60, "t4_idle");
    corrupt = 1'b0;
    check("t4_err", err, 1);
    check("t4_valid_cnt", valid_cnt - b_v, 1);
    check("t4_we_cnt", we_cnt - b_we, NUM_SEG);
    check("t4_bad_idx_written", log_idx[b_log + 2], 3);
    check("t4_next_idx", log_idx[b_log + 3], 3);
    b_v = valid_cnt;
    pulse_start("t4b_busy_start");
    drive_frame(NUM_SEG, -1, -1, st);
    wait_idle(60, "t4b_idle");
    check("t4b_err_sticky", err, 1);
    check("t4b_valid_cnt", valid_cnt - b_v, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_err_cleared", err, 0);

    // 5: start during ISSUE is ignored; a result in IDLE is spurious
    b_we = we_cnt; b_v = valid_cnt; b_req = req_cnt; b_log = log_idx.size();
    pulse_start("t5_busy_start");
    drive_frame(NUM_SEG, -1, 4, st);
    wait_idle(60, "t5_idle");
    check("t5_valid_cnt", valid_cnt - b_v, 1);
    check("t5_we_cnt", we_cnt - b_we, NUM_SEG);
    check("t5_req_cnt", req_cnt - b_req, NUM_SEG);
    check("t5_last_idx", log_idx[b_log + NUM_SEG - 1], NUM_SEG - 1);
    check("t5_err_clean", err, 0);
    b_we = we_cnt;
    spur_req = 1'b1;
    @(negedge clk);
    spur_req = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_spur_err", err, 1);
    check("t5_spur_no_we", we_cnt - b_we, 0);
    check("t5_spur_busy", busy, 0);

    // 6: reset during DRAIN, then a clean frame
    lat = 5;
    pulse_start("t6_busy_start");
    drive_frame(NUM_SEG, -1, -1, st);
    check("t6_drain_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_all_zero("t6_async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    lat = 2;
    b_we = we_cnt; b_v = valid_cnt; b_log = log_idx.size();
    pulse_start("t6b_busy_start");
    drive_frame(NUM_SEG, -1, -1, st);
    wait_idle(60, "t6b_idle");
    check("t6b_valid_cnt", valid_cnt - b_v, 1);
    check("t6b_we_cnt", we_cnt - b_we, NUM_SEG);
    check("t6b_first_idx", log_idx[b_log], 0);
    check("t6b_last_idx", log_idx[b_log + NUM_SEG - 1], NUM_SEG - 1);
    check("t6b_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
